collision_game_fsm: RTL and testbench



---
 rtl/collision_game_fsm.sv | 182 ++++++++++++++++++
 tb/tb_collision_game_fsm.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/collision_game_fsm.sv
// Collision detection, IDLE/RUN/DEAD game state machine and BCD score keeper.
// Sits after the pixel compositor; o_run gates obstacle and dino animation.
module collision_game_fsm #(
    parameter int unsigned SCORE_DIV = 6,
    parameter int unsigned DEAD_HOLD = 30
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_pix_stb,
    input  logic        i_animate,
    input  logic        i_active,
    input  logic [9:0]  i_x,
    input  logic [8:0]  i_y,
    input  logic        i_px_dino,
    input  logic        i_px_obstacle,
    input  logic        i_btn,
    output logic [1:0]  o_state,
    output logic        o_run,
    output logic        o_new_game,
    output logic        o_game_over,
    output logic [15:0] o_score,
    output logic [9:0]  o_hit_x,
    output logic [8:0]  o_hit_y
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDead = 2'd2,
        StBad  = 2'd3
    } state_e;

    localparam logic [5:0]  FrameLast = 6'(SCORE_DIV - 1);
    localparam logic [7:0]  DeadHold  = 8'(DEAD_HOLD);
    localparam logic [15:0] ScoreMax  = 16'h9999;

    state_e      state_q, state_d;
    logic        btn_s1_q, btn_s2_q, btn_prev_q;
    logic [5:0]  frame_cnt_q, frame_cnt_d;
    logic [7:0]  dead_cnt_q, dead_cnt_d;
    logic        hit_flag_q, hit_flag_d;
    logic [15:0] score_q, score_d;
    logic [9:0]  hit_x_q, hit_x_d;
    logic [8:0]  hit_y_q, hit_y_d;
    logic        new_game_q, new_game_d;
    logic        run_q, run_d;
    logic        over_q, over_d;

    logic start;
    logic ftick;
    logic hit;

    // Four-digit BCD increment with ripple carry between digits.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign start = btn_s2_q & ~btn_prev_q;
    assign ftick = i_animate & i_pix_stb;
    assign hit   = i_pix_stb & i_active & i_px_dino & i_px_obstacle;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= StIdle;
            btn_s1_q    <= 1'b0;
            btn_s2_q    <= 1'b0;
            btn_prev_q  <= 1'b0;
            frame_cnt_q <= '0;
            dead_cnt_q  <= '0;
            hit_flag_q  <= 1'b0;
            score_q     <= '0;
            hit_x_q     <= '0;
            hit_y_q     <= '0;
            new_game_q  <= 1'b0;
            run_q       <= 1'b0;
            over_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            btn_s1_q    <= i_btn;
            btn_s2_q    <= btn_s1_q;
            btn_prev_q  <= btn_s2_q;
            frame_cnt_q <= frame_cnt_d;
            dead_cnt_q  <= dead_cnt_d;
            hit_flag_q  <= hit_flag_d;
            score_q     <= score_d;
            hit_x_q     <= hit_x_d;
            hit_y_q     <= hit_y_d;
            new_game_q  <= new_game_d;
            run_q       <= run_d;
            over_q      <= over_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        dead_cnt_d  = dead_cnt_q;
        hit_flag_d  = hit_flag_q;
        score_d     = score_q;
        hit_x_d     = hit_x_q;
        hit_y_d     = hit_y_q;
        new_game_d  = 1'b0;

        case (state_q)
            StIdle: begin
                score_d = '0;
                if (start) begin
                    state_d     = StRun;
                    new_game_d  = 1'b1;
                    frame_cnt_d = '0;
                    hit_flag_d  = 1'b0;
                    dead_cnt_d  = '0;
                end
            end
            StRun: begin
                if (hit && !hit_flag_q) begin
                    hit_flag_d = 1'b1;
                    hit_x_d    = i_x;
                    hit_y_d    = i_y;
                end
                if (ftick) begin
                    if (hit_flag_q || hit) begin
                        state_d    = StDead;
                        dead_cnt_d = '0;
                    end else begin
                        hit_flag_d = 1'b0;
                        if (frame_cnt_q >= FrameLast) begin
                            frame_cnt_d = '0;
                            if (score_q != ScoreMax) begin
                                score_d = bcd_inc(score_q);
                            end
                        end else begin
                            frame_cnt_d = frame_cnt_q + 6'd1;
                        end
                    end
                end
            end
            StDead: begin
                // A start arriving with a frame tick sees the pre-increment count.
                if (start && dead_cnt_q == DeadHold) begin
                    state_d     = StRun;
                    new_game_d  = 1'b1;
                    score_d     = '0;
                    dead_cnt_d  = '0;
                    frame_cnt_d = '0;
                    hit_flag_d  = 1'b0;
                end else if (ftick && dead_cnt_q != DeadHold) begin
                    dead_cnt_d = dead_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        run_d  = (state_d == StRun);
        over_d = (state_d == StDead);
    end

    assign o_state     = state_q;
    assign o_run       = run_q;
    assign o_new_game  = new_game_q;
    assign o_game_over = over_q;
    assign o_score     = score_q;
    assign o_hit_x     = hit_x_q;
    assign o_hit_y     = hit_y_q;

endmodule

// File: tb/tb_collision_game_fsm.sv
// Bench for collision_game_fsm: directed scenarios plus randomized games checked
// against a frame-level model of survival, scoring and first-hit capture.
module tb_collision_game_fsm;

    localparam int unsigned SCORE_DIV = 6;
    localparam int unsigned DEAD_HOLD = 30;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_stb, animate, active, px_dino, px_obs, btn;
    logic [9:0]  x;
    logic [8:0]  y;
    logic [1:0]  state;
    logic        run, new_game, game_over;
    logic [15:0] score;
    logic [9:0]  hit_x;
    logic [8:0]  hit_y;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    collision_game_fsm #(
        .SCORE_DIV(SCORE_DIV),
        .DEAD_HOLD(DEAD_HOLD)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_pix_stb    (pix_stb),
        .i_animate    (animate),
        .i_active     (active),
        .i_x          (x),
        .i_y          (y),
        .i_px_dino    (px_dino),
        .i_px_obstacle(px_obs),
        .i_btn        (btn),
        .o_state      (state),
        .o_run        (run),
        .o_new_game   (new_game),
        .o_game_over  (game_over),
        .o_score      (score),
        .o_hit_x      (hit_x),
        .o_hit_y      (hit_y)
    );

    // Expected score after a number of survived frames, saturating at 9999.
    function automatic logic [15:0] to_bcd(input int v);
        int s;
        s = (v > 9999) ? 9999 : v;
        return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pix_stb = 1'b0; animate = 1'b0; active = 1'b0;
        px_dino = 1'b0; px_obs = 1'b0; x = '0; y = '0;
    endtask

    task automatic tick();
        idle_inputs();
        pix_stb = 1'b1; animate = 1'b1;
        cyc();
        idle_inputs();
    endtask

    task automatic release_btn();
        btn = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic dead_restart();
        repeat (DEAD_HOLD) tick();
        btn = 1'b1;
        repeat (3) cyc();
        checks++;
        if (new_game !== 1'b1 || state !== 2'd1 || score !== 16'h0000) begin
            failures++;
            $display("FAIL restart: ng=%b state=%0d score=%h want ng=1 state=1 score=0000",
                     new_game, state, score);
        end
        release_btn();
    endtask

    task automatic test_reset();
        idle_inputs();
        btn = 1'b0;
        rst = 1'b1;
        cyc();
        cyc();
        checks++;
        if ({state, run, new_game, game_over, score, hit_x, hit_y} !== '0) begin
            failures++;
            $display("FAIL reset_vals: state=%0d run=%b ng=%b go=%b score=%h hx=%0d hy=%0d want 0",
                     state, run, new_game, game_over, score, hit_x, hit_y);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pix_stb = 1'b1; animate = 1'b1; active = 1'b1; px_dino = 1'b1; px_obs = 1'b1;
            cyc();
            idle_inputs();
            checks++;
            if (state !== 2'd0 || score !== 16'h0000 || run !== 1'b0) begin
                failures++;
                $display("FAIL idle_hold: state=%0d score=%h run=%b want 0/0000/0",
                         state, score, run);
            end
        end
    endtask

    task automatic test_start();
        btn = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            cyc();
            checks++;
            if (new_game !== (i == 3)) begin
                failures++;
                $display("FAIL start_latency clk%0d: ng=%b want %b", i, new_game, i == 3);
            end
        end
        checks++;
        if (state !== 2'd1 || run !== 1'b1) begin
            failures++;
            $display("FAIL start_state: state=%0d run=%b want 1/1", state, run);
        end
        for (int i = 0; i < 8; i++) begin
            cyc();
            checks++;
            if (new_game !== 1'b0) begin
                failures++;
                $display("FAIL start_held: ng=%b want 0 at hold cycle %0d", new_game, i);
            end
        end
        release_btn();
    endtask

    task automatic test_score();
        int frames;
        frames = 0;
        repeat (60) begin
            tick();
            frames++;
        end
        checks++;
        if (score !== 16'h0010) begin
            failures++;
            $display("FAIL score_60: got %h want 0010", score);
        end
        // One frame tick per cycle to reach the top of the range quickly.
        pix_stb = 1'b1; animate = 1'b1;
        while (frames < 9998 * SCORE_DIV) begin
            active = 1'($urandom); px_dino = 1'($urandom);
            cyc();
            frames++;
            if (frames % 1500 == 0) begin
                checks++;
                if (score !== to_bcd(frames / SCORE_DIV)) begin
                    failures++;
                    $display("FAIL score_run f=%0d: got %h want %h",
                             frames, score, to_bcd(frames / SCORE_DIV));
                end
            end
        end
        checks++;
        if (score !== 16'h9998) begin
            failures++;
            $display("FAIL score_9998: got %h want 9998", score);
        end
        repeat (SCORE_DIV) begin
            cyc();
            frames++;
        end
        checks++;
        if (score !== 16'h9999) begin
            failures++;
            $display("FAIL score_9999: got %h want 9999", score);
        end
        repeat (11 * SCORE_DIV) begin
            cyc();
            frames++;
        end
        idle_inputs();
        checks++;
        if (score !== to_bcd(frames / SCORE_DIV) || score !== 16'h9999) begin
            failures++;
            $display("FAIL score_sat: got %h want 9999", score);
        end
    endtask

    task automatic test_start_in_run();
        btn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            checks++;
            if (new_game !== 1'b0 || state !== 2'd1) begin
                failures++;
                $display("FAIL run_start_ignored: ng=%b state=%0d want 0/1", new_game, state);
            end
        end
        release_btn();
    endtask

    task automatic test_capture();
        logic [9:0] xs [3];
        logic [8:0] ys [3];
        xs = '{10'd100, 10'd101, 10'd102};
        ys = '{9'd300, 9'd300, 9'd301};
        for (int i = 0; i < 3; i++) begin
            pix_stb = 1'b1; active = 1'b1; px_dino = 1'b1; px_obs = 1'b1;
            x = xs[i]; y = ys[i];
            cyc();
            checks++;
            if (state !== 2'd1) begin
                failures++;
                $display("FAIL capture_midframe: state=%0d want 1", state);
            end
        end
        idle_inputs();
        cyc();
        tick();
        checks++;
        if (state !== 2'd2 || game_over !== 1'b1 || run !== 1'b0) begin
            failures++;
            $display("FAIL capture_dead: state=%0d go=%b run=%b want 2/1/0", state, game_over, run);
        end
        checks++;
        if (hit_x !== 10'd100 || hit_y !== 9'd300 || score !== 16'h9999) begin
            failures++;
            $display("FAIL capture_xy: hx=%0d hy=%0d score=%h want 100/300/9999",
                     hit_x, hit_y, score);
        end
    endtask

    task automatic test_dead_hold();
        repeat (10) tick();
        btn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            checks++;
            if (new_game !== 1'b0 || state !== 2'd2) begin
                failures++;
                $display("FAIL dead_early10: ng=%b state=%0d want 0/2", new_game, state);
            end
        end
        release_btn();
        repeat (19) tick();
        // Start pulse lands on the same cycle as the 30th tick.
        btn = 1'b1;
        cyc();
        cyc();
        pix_stb = 1'b1; animate = 1'b1;
        cyc();
        idle_inputs();
        cyc();
        checks++;
        if (new_game !== 1'b0 || state !== 2'd2 || hit_x !== 10'd100 || hit_y !== 9'd300) begin
            failures++;
            $display("FAIL dead_start_with_tick: ng=%b state=%0d hx=%0d hy=%0d want 0/2/100/300",
                     new_game, state, hit_x, hit_y);
        end
        release_btn();
        btn = 1'b1;
        repeat (3) cyc();
        checks++;
        if (new_game !== 1'b1 || state !== 2'd1 || score !== 16'h0000 || game_over !== 1'b0) begin
            failures++;
            $display("FAIL dead_restart30: ng=%b state=%0d score=%h go=%b want 1/1/0000/0",
                     new_game, state, score, game_over);
        end
        cyc();
        checks++;
        if (new_game !== 1'b0) begin
            failures++;
            $display("FAIL dead_restart_pulse: ng=%b want 0", new_game);
        end
        release_btn();
    endtask

    task automatic test_tick_hit();
        repeat (SCORE_DIV - 2) tick();
        // Overlap without active or without strobe must not count as a collision.
        pix_stb = 1'b1; active = 1'b0; px_dino = 1'b1; px_obs = 1'b1; x = 10'd5; y = 9'd6;
        cyc();
        pix_stb = 1'b0; active = 1'b1;
        cyc();
        tick();
        checks++;
        if (state !== 2'd1 || score !== 16'h0000) begin
            failures++;
            $display("FAIL no_hit_gated: state=%0d score=%h want 1/0000", state, score);
        end
        pix_stb = 1'b1; animate = 1'b1; active = 1'b1; px_dino = 1'b1; px_obs = 1'b1;
        x = 10'd7; y = 9'd9;
        cyc();
        idle_inputs();
        checks++;
        if (state !== 2'd2 || score !== 16'h0000 || hit_x !== 10'd7 || hit_y !== 9'd9) begin
            failures++;
            $display("FAIL tick_hit: state=%0d score=%h hx=%0d hy=%0d want 2/0000/7/9",
                     state, score, hit_x, hit_y);
        end
    endtask

    task automatic test_random_games();
        int         frames;
        logic       hit_seen, dead, h;
        logic [9:0] hx;
        logic [8:0] hy;
        int         n;
        for (int g = 0; g < 5; g++) begin
            frames = 0;
            dead   = 1'b0;
            for (int f = 0; f < 40 && !dead; f++) begin
                hit_seen = 1'b0;
                hx = '0;
                hy = '0;
                n = int'($urandom_range(1, 5));
                for (int c = 0; c <= n; c++) begin
                    pix_stb = ($urandom % 4) != 0;
                    active  = ($urandom % 4) != 0;
                    px_dino = 1'($urandom);
                    px_obs  = ($urandom % 12) == 0;
                    animate = ($urandom % 8) == 0;
                    if (f == 39 && c == 0) begin
                        pix_stb = 1'b1; active = 1'b1; px_dino = 1'b1; px_obs = 1'b1;
                    end
                    if (c == n) begin
                        animate = 1'b1; pix_stb = 1'b1;
                    end else if (animate) begin
                        pix_stb = 1'b0;
                    end
                    x = 10'($urandom % 640);
                    y = 9'($urandom % 480);
                    h = pix_stb & active & px_dino & px_obs;
                    if (h && !hit_seen) begin
                        hit_seen = 1'b1;
                        hx = x;
                        hy = y;
                    end
                    cyc();
                    if (c < n) begin
                        checks++;
                        if (state !== 2'd1) begin
                            failures++;
                            $display("FAIL rand_midframe g=%0d f=%0d: state=%0d want 1",
                                     g, f, state);
                        end
                    end
                end
                idle_inputs();
                if (hit_seen) begin
                    dead = 1'b1;
                end else begin
                    frames++;
                end
                checks++;
                if (state !== (dead ? 2'd2 : 2'd1) || game_over !== dead ||
                    score !== to_bcd(frames / SCORE_DIV)) begin
                    failures++;
                    $display("FAIL rand_frame g=%0d f=%0d: state=%0d go=%b score=%h want %0d/%b/%h",
                             g, f, state, game_over, score, dead ? 2 : 1, dead,
                             to_bcd(frames / SCORE_DIV));
                end
                if (dead) begin
                    checks++;
                    if (hit_x !== hx || hit_y !== hy) begin
                        failures++;
                        $display("FAIL rand_capture g=%0d: hx=%0d hy=%0d want %0d/%0d",
                                 g, hit_x, hit_y, hx, hy);
                    end
                end
            end
            dead_restart();
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        btn = 1'b1;
        repeat (3) cyc();
        release_btn();
        repeat (42 * SCORE_DIV) tick();
        checks++;
        if (score !== 16'h0042 || state !== 2'd1) begin
            failures++;
            $display("FAIL pre_reset_score: score=%h state=%0d want 0042/1", score, state);
        end
        pix_stb = 1'b1; active = 1'b1; px_dino = 1'b1; px_obs = 1'b1; x = 10'd321; y = 9'd123;
        cyc();
        idle_inputs();
        checks++;
        if (hit_x !== 10'd321 || hit_y !== 9'd123) begin
            failures++;
            $display("FAIL pre_reset_capture: hx=%0d hy=%0d want 321/123", hit_x, hit_y);
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({state, run, new_game, game_over, score, hit_x, hit_y} !== '0) begin
            failures++;
            $display("FAIL async_reset: state=%0d run=%b ng=%b go=%b score=%h hx=%0d hy=%0d want 0",
                     state, run, new_game, game_over, score, hit_x, hit_y);
        end
        cyc();
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (state !== 2'd0 || score !== 16'h0000 || run !== 1'b0) begin
                failures++;
                $display("FAIL post_reset_idle: state=%0d score=%h run=%b want 0/0000/0",
                         state, score, run);
            end
        end
        btn = 1'b1;
        repeat (3) cyc();
        checks++;
        if (new_game !== 1'b1 || state !== 2'd1) begin
            failures++;
            $display("FAIL post_reset_start: ng=%b state=%0d want 1/1", new_game, state);
        end
        release_btn();
    endtask

    initial begin
        btn = 1'b0;
        idle_inputs();
        test_reset();
        test_start();
        test_score();
        test_start_in_run();
        test_capture();
        test_dead_hold();
        test_tick_hit();
        dead_restart();
        test_random_games();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
